// File: rtl/controlador_tampador_pkg.sv
// Shared types and default constants for the cap-station controller.
package controlador_tampador_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CAP   = 3'd2,
    REQ   = 3'd3,
    SAIDA = 3'd4,
    FALHA = 3'd5
  } estado_t;

  localparam int DEB_N_DEF       = 3;
  localparam int T_TAMPA_DEF     = 4;
  localparam int T_REPOSICAO_DEF = 1000;
  localparam int W_CONT_DEF      = 8;

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controlador_tampador_debouncer_sinc.sv
// Synchronous debouncer: accepts a new level after DEB_N consecutive differing samples.
module debouncer_sinc
  import controlador_tampador_pkg::*;
#(
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bruto,
  output logic g_f,
  output logic g_rise
);

  localparam int CW = (DEB_N < 2) ? 1 : $clog2(DEB_N + 1);

  logic [CW-1:0] corrida;
  logic          aceita;

  assign aceita = (bruto != g_f) && (corrida == CW'(DEB_N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      g_f     <= 1'b0;
      g_rise  <= 1'b0;
      corrida <= '0;
    end else begin
      g_rise <= aceita && bruto;
      // Any sample equal to the filtered level restarts the run.
      if (bruto == g_f) begin
        corrida <= '0;
      end else if (aceita) begin
        g_f     <= bruto;
        corrida <= '0;
      end else begin
        corrida <= corrida + 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_tampador.sv
// Cap-station controller: stops the conveyor per bottle, caps it or requests stock.
module controlador_tampador
  import controlador_tampador_pkg::*;
#(
  parameter int DEB_N       = DEB_N_DEF,
  parameter int T_TAMPA     = T_TAMPA_DEF,
  parameter int T_REPOSICAO = T_REPOSICAO_DEF,
  parameter int W_CONT      = W_CONT_DEF
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              garrafa,
  input  logic              TemR,
  output logic              Tampar,
  output logic              adicionar,
  output logic              esteira,
  output logic              alarme,
  output logic [W_CONT-1:0] contagem
);

  localparam int TW = $clog2(maximo(T_TAMPA, T_REPOSICAO) + 1);

  estado_t       estado, prox;
  logic [TW-1:0] tmr;
  logic          g_f, g_rise;

  debouncer_sinc #(.DEB_N(DEB_N)) u_deb (
    .clk    (CK),
    .rst    (RST),
    .bruto  (garrafa),
    .g_f    (g_f),
    .g_rise (g_rise)
  );

  always_comb begin
    prox = estado;
    case (estado)
      IDLE:    if (g_rise) prox = CHECK;
      CHECK:   prox = TemR ? CAP : REQ;
      CAP:     if (tmr == TW'(T_TAMPA - 1)) prox = SAIDA;
      // Stock arriving on the timeout cycle still wins.
      REQ: begin
        if (TemR)                              prox = CAP;
        else if (tmr == TW'(T_REPOSICAO - 1)) prox = FALHA;
      end
      SAIDA:   if (!g_f) prox = IDLE;
      FALHA:   prox = FALHA;
      default: prox = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      estado    <= IDLE;
      tmr       <= '0;
      Tampar    <= 1'b0;
      adicionar <= 1'b0;
      esteira   <= 1'b1;
      alarme    <= 1'b0;
      contagem  <= '0;
    end else begin
      estado <= prox;
      // Timer restarts on every state change so each timed state counts from 0.
      if (prox != estado || !(estado == CAP || estado == REQ))
        tmr <= '0;
      else
        tmr <= tmr + 1'b1;
      Tampar    <= (prox == CAP) && (estado != CAP);
      adicionar <= (prox == REQ);
      esteira   <= (prox == IDLE) || (prox == SAIDA);
      alarme    <= (prox == FALHA);
      if (estado == CAP && prox == SAIDA && contagem != '1)
        contagem <= contagem + 1'b1;
    end
  end

endmodule

// File: doc/controlador_tampador.md
Name: controlador_tampador

Overview:
- Cap-station controller: the consumer side of the cap-stock counter.
- Detects a bottle on the conveyor and stops the conveyor.
- Issues a single-cycle Tampar pulse when stock is available (TemR=1).
- Otherwise holds an adicionar replenish request until stock appears or a timeout expires.
- Counts capped bottles for the display path (binary out; BCD/7-seg conversion downstream).

Parameters:
- DEB_N, 3, consecutive stable cycles required to accept a change of the garrafa sensor.
- T_TAMPA, 4, cycles the cap actuator is held (conveyor stopped) after the Tampar pulse.
- T_REPOSICAO, 1000, maximum cycles adicionar is held waiting for TemR before a fault.
- W_CONT, 8, width of the capped-bottle counter.

Ports:
- CK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- garrafa  in  1  raw bottle-present sensor; level, may bounce.
- TemR  in  1  stock-available flag from the cap-stock counter; level.
- Tampar  out  1  cap-consume pulse; exactly 1 cycle wide per bottle.
- adicionar  out  1  replenish request; level.
- esteira  out  1  conveyor enable.
- alarme  out  1  fault flag; sticky until RST.
- contagem  out  W_CONT  capped-bottle count, saturating.

Behaviour:
- Reset (RST sampled high at a CK edge):
  - state=IDLE, Tampar=0, adicionar=0, alarme=0, esteira=1, contagem=0.
  - Debounce filter cleared with the filtered value = 0.
  - All timers cleared.
  - RST dominates in every state, including mid-CAP and mid-REQ. A Tampar pulse never appears in the cycle after RST.
- Debounce:
  - The filtered level g_f takes the new raw value after garrafa differs from g_f for DEB_N consecutive samples.
  - Any glitch restarts the run count.
  - g_rise is a 1-cycle strobe when g_f goes 0->1.
- All outputs are registered and decoded from the state / next-state registers.
- IDLE:
  - esteira=1.
  - On g_rise -> CHECK.
- CHECK (1 cycle):
  - esteira=0.
  - TemR=1 -> CAP; TemR=0 -> REQ.
- CAP:
  - esteira=0.
  - Tampar=1 only in the first CAP cycle.
  - Timer runs T_TAMPA cycles, then -> SAIDA.
  - contagem+1 on CAP exit, saturating at 2^W_CONT-1 with no wrap.
- REQ:
  - esteira=0, adicionar=1.
  - Timer counts up from 0.
  - TemR=1 -> CAP, with adicionar dropping in the same cycle Tampar rises.
  - Timer reaches T_REPOSICAO with TemR still 0 -> FALHA.
  - If TemR and the timeout coincide, TemR wins -> CAP.
- SAIDA:
  - esteira=1.
  - Waits for g_f=0, then -> IDLE.
  - A new bottle is not accepted until g_f has fallen.
- FALHA:
  - alarme=1, esteira=0, adicionar=0, Tampar=0.
  - Terminal until RST.
- Latency:
  - Stable garrafa edge to esteira=0: DEB_N+1 cycles.
  - CHECK to Tampar: 1 cycle.
- Sensor bounce during CAP/REQ is ignored; only SAIDA and IDLE consult g_f.
- TemR is sampled only in CHECK and REQ; a fall of TemR during CAP does not abort the cap.
- Exactly one Tampar per accepted bottle, never more.

Decomposition:
- Shared package:
  - State enum {IDLE, CHECK, CAP, REQ, SAIDA, FALHA}.
  - Default constants for DEB_N, T_TAMPA, T_REPOSICAO.
- One sub-module: debouncer_sinc.
  - Parameterised DEB_N, synchronous active-high reset.
  - Outputs g_f and g_rise.
  - Reusable for the operator buttons elsewhere in the design.
- FSM, timer and counter stay in the top.

Test Plan:
- Stock present:
  - Stimulus: RST 2 cycles, TemR=1, garrafa held 1 from cycle 10.
  - Response: esteira=0 at cycle 14; Tampar=1 only at cycle 15; contagem=1 after CAP exits; esteira=1 in SAIDA.
  - Then garrafa=0: state returns to IDLE after 3 stable cycles.
- Bounce rejection:
  - Stimulus: garrafa pulses 1 for 2 cycles, 0 for 1, 1 for 2, then 0.
  - Response: no g_rise, esteira stays 1, Tampar never asserted.
- Replenish success:
  - Stimulus: TemR=0 at bottle arrival; TemR raised 50 cycles into REQ.
  - Response: adicionar=1 for the whole wait; adicionar=0 and Tampar=1 in the same cycle; contagem increments.
- Replenish timeout:
  - Stimulus: TemR=0 held with T_REPOSICAO=20.
  - Response: after 20 REQ cycles, alarme=1, adicionar=0, esteira=0; no Tampar ever; these persist until RST.
  - RST clears all outputs.
- Saturation:
  - Stimulus: W_CONT=2, 5 bottles with TemR=1.
  - Response: contagem 1,2,3,3,3; 5 Tampar pulses.
- Reset mid-CAP:
  - Stimulus: RST asserted in the 2nd CAP cycle.
  - Response: next cycle IDLE, esteira=1, contagem=0, no further Tampar.
  - Then a new bottle is capped normally.
